// File: rtl/matrix_accel_soc.sv
// Control-register bank reachable from the JTAG REGACC data register.
//   clk, rst_n  : system clock, async active-low reset
//   wr_en       : one-cycle write strobe; addr/wdata qualify it
//   addr        : 6-bit register address, also selects the read data
//   uart_busy   : UART transmitter busy flag, read back at addr 1
//   rdata       : combinational read data for addr
//   uart_start  : accepted UART write (addr 1 while idle)
//   reg_q_o     : register contents; reg_q_o[0] == 32'hFF ends simulation
module ctrl_regs #(
    parameter int unsigned PRF_LOG_P = 1,
    parameter int unsigned PRF_LOG_Q = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [5:0]  addr,
    input  logic [31:0] wdata,
    input  logic        uart_busy,
    output logic [31:0] rdata,
    output logic        uart_start,
    output logic [31:0] reg_q_o [0:3]
);

    localparam logic [31:0] CfgValue = {16'h0, 8'(PRF_LOG_Q), 8'(PRF_LOG_P)};

    logic [31:0] reg0_q, reg1_q, reg3_q;

    assign uart_start = wr_en && (addr == 6'd1) && !uart_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg0_q <= '0;
            reg1_q <= '0;
            reg3_q <= '0;
        end else if (wr_en) begin
            if (addr == 6'd0) reg0_q <= wdata;
            if (uart_start)   reg1_q <= {24'h0, wdata[7:0]};
            if (addr == 6'd3) reg3_q <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            6'd0:    rdata = reg0_q;
            6'd1:    rdata = {31'b0, uart_busy};
            6'd2:    rdata = CfgValue;
            6'd3:    rdata = reg3_q;
            default: rdata = '0;
        endcase
    end

    assign reg_q_o[0] = reg0_q;
    assign reg_q_o[1] = reg1_q;
    assign reg_q_o[2] = CfgValue;
    assign reg_q_o[3] = reg3_q;

endmodule

// Simulation-facing SoC top: clk-oversampled JTAG TAP, control registers and
// an 8N1 UART transmitter.
//   clk, rst_n              : system clock, async active-low reset
//   tx / rx                 : UART transmit (idle high) / receive (unused)
//   tck, tms, trstn, tdi    : JTAG inputs, asynchronous to clk
//   tdo                     : JTAG data out, changes after a detected tck fall
// IDCODE bit0 must be 1.
module matrix_accel_soc #(
    parameter int unsigned PRF_LOG_P    = 1,
    parameter int unsigned PRF_LOG_Q    = 2,
    parameter logic [31:0] IDCODE       = 32'h249511C3,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    output logic tx,
    input  logic rx,
    input  logic tck,
    input  logic tms,
    input  logic trstn,
    input  logic tdi,
    output logic tdo
);

    typedef enum logic [3:0] {
        StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauseDr, StEx2Dr, StUpdDr,
        StSelIr, StCapIr, StShIr, StEx1Ir, StPauseIr, StEx2Ir, StUpdIr
    } tap_state_e;

    typedef enum logic [1:0] {StTxIdle, StTxStart, StTxData, StTxStop} tx_state_e;

    localparam logic [4:0]  IrIdcode = 5'h01;
    localparam logic [4:0]  IrRegacc = 5'h11;
    localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    // ---------------- JTAG synchronizers and edge detect ----------------
    logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trstn_sync_q;
    logic       tck_prev_q;
    logic       tck_rise, tck_fall, tms_s, tdi_s, trstn_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync_q   <= '0;
            tms_sync_q   <= '0;
            tdi_sync_q   <= '0;
            trstn_sync_q <= '0;
            tck_prev_q   <= 1'b0;
        end else begin
            tck_sync_q   <= {tck_sync_q[0], tck};
            tms_sync_q   <= {tms_sync_q[0], tms};
            tdi_sync_q   <= {tdi_sync_q[0], tdi};
            trstn_sync_q <= {trstn_sync_q[0], trstn};
            tck_prev_q   <= tck_sync_q[1];
        end
    end

    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];
    assign trstn_s  = trstn_sync_q[1];
    assign tck_rise = tck_sync_q[1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[1] & tck_prev_q;

    // ---------------- TAP state machine ----------------
    tap_state_e tap_q, tap_d, tap_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tap_q <= StTlr;
        else        tap_q <= tap_d;
    end

    always_comb begin
        tap_next = tap_q;
        unique case (tap_q)
            StTlr:     tap_next = tms_s ? StTlr   : StRti;
            StRti:     tap_next = tms_s ? StSelDr : StRti;
            StSelDr:   tap_next = tms_s ? StSelIr : StCapDr;
            StCapDr:   tap_next = tms_s ? StEx1Dr : StShDr;
            StShDr:    tap_next = tms_s ? StEx1Dr : StShDr;
            StEx1Dr:   tap_next = tms_s ? StUpdDr : StPauseDr;
            StPauseDr: tap_next = tms_s ? StEx2Dr : StPauseDr;
            StEx2Dr:   tap_next = tms_s ? StUpdDr : StShDr;
            StUpdDr:   tap_next = tms_s ? StSelDr : StRti;
            StSelIr:   tap_next = tms_s ? StTlr   : StCapIr;
            StCapIr:   tap_next = tms_s ? StEx1Ir : StShIr;
            StShIr:    tap_next = tms_s ? StEx1Ir : StShIr;
            StEx1Ir:   tap_next = tms_s ? StUpdIr : StPauseIr;
            StPauseIr: tap_next = tms_s ? StEx2Ir : StPauseIr;
            StEx2Ir:   tap_next = tms_s ? StUpdIr : StShIr;
            StUpdIr:   tap_next = tms_s ? StSelDr : StRti;
            default:   tap_next = StTlr;
        endcase
        tap_d = tap_q;
        if (!trstn_s)      tap_d = StTlr;
        else if (tck_rise) tap_d = tap_next;
    end

    // ---------------- IR / DR shift paths ----------------
    logic [4:0]  ir_q, ir_sh_q;
    logic [39:0] dr_q, dr_capture, dr_shifted;
    logic        upd_dr_q;
    logic [5:0]  last_addr_q;
    logic [31:0] rdata_q, bank_rdata;

    always_comb begin
        dr_capture = '0;
        dr_shifted = {39'h0, tdi_s};
        if (ir_q == IrIdcode) begin
            dr_capture = {8'h0, IDCODE};
            dr_shifted = {8'h0, tdi_s, dr_q[31:1]};
        end else if (ir_q == IrRegacc) begin
            dr_capture = {last_addr_q, rdata_q, 2'b00};
            dr_shifted = {tdi_s, dr_q[39:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q     <= IrIdcode;
            ir_sh_q  <= '0;
            dr_q     <= '0;
            tdo      <= 1'b0;
            upd_dr_q <= 1'b0;
        end else if (!trstn_s) begin
            ir_q     <= IrIdcode;
            tdo      <= 1'b0;
            upd_dr_q <= 1'b0;
        end else begin
            // Register access fires the clk after the rise that enters Update-DR.
            upd_dr_q <= tck_rise && (tap_next == StUpdDr) && (ir_q == IrRegacc);
            if (tap_q == StTlr) ir_q <= IrIdcode;
            if (tck_rise) begin
                case (tap_q)
                    StCapIr: ir_sh_q <= 5'b00001;
                    StShIr:  ir_sh_q <= {tdi_s, ir_sh_q[4:1]};
                    StCapDr: dr_q    <= dr_capture;
                    StShDr:  dr_q    <= dr_shifted;
                    default: ;
                endcase
                if (tap_next == StUpdIr) ir_q <= ir_sh_q;
            end
            if (tck_fall) begin
                if (tap_q == StShDr)      tdo <= dr_q[0];
                else if (tap_q == StShIr) tdo <= ir_sh_q[0];
                else                      tdo <= 1'b0;
            end
        end
    end

    // ---------------- REGACC execution ----------------
    logic        reg_wr, reg_rd, uart_start, uart_busy;
    logic [31:0] reg_q [0:3];

    assign reg_wr = upd_dr_q && (dr_q[1:0] == 2'd2);
    assign reg_rd = upd_dr_q && (dr_q[1:0] == 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= '0;
            last_addr_q <= '0;
        end else if (reg_rd) begin
            rdata_q     <= bank_rdata;
            last_addr_q <= dr_q[39:34];
        end
    end

    ctrl_regs #(
        .PRF_LOG_P (PRF_LOG_P),
        .PRF_LOG_Q (PRF_LOG_Q)
    ) i_ctrl_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (reg_wr),
        .addr       (dr_q[39:34]),
        .wdata      (dr_q[33:2]),
        .uart_busy  (uart_busy),
        .rdata      (bank_rdata),
        .uart_start (uart_start),
        .reg_q_o    (reg_q)
    );

    // ---------------- UART transmitter ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            bit_end;

    assign bit_end   = (cnt_q == CntMax);
    assign uart_busy = (tx_state_q != StTxIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= StTxIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        tx         = 1'b1;
        unique case (tx_state_q)
            StTxIdle: begin
                if (uart_start) begin
                    tx_state_d = StTxStart;
                    cnt_d      = '0;
                    sh_d       = dr_q[9:2];
                end
            end
            StTxStart: begin
                tx    = 1'b0;
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    tx_state_d = StTxData;
                end
            end
            StTxData: begin
                tx    = sh_q[0];
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) tx_state_d = StTxStop;
                end
            end
            StTxStop: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d      = '0;
                    tx_state_d = StTxIdle;
                end
            end
            default: tx_state_d = StTxIdle;
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{rx, reg_q[0], reg_q[1], reg_q[2], reg_q[3]};

endmodule

// File: tb/tb_matrix_accel_soc.sv
// Self-checking bench for matrix_accel_soc: drives JTAG as a bit-banged host,
// models the register bank at transaction level and decodes UART frames.
module tb_matrix_accel_soc;

    localparam int unsigned PrfLogP = 1;
    localparam int unsigned PrfLogQ = 2;
    localparam logic [31:0] IdCode  = 32'h249511C3;
    localparam int          Clks    = 128;
    localparam int          Half    = 6;

    logic clk = 1'b0;
    logic rst_n, tck, tms, trstn, tdi;
    logic tx, tdo;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the register bank and REGACC capture.
    logic [31:0] m_reg0, m_reg3, m_rdata;
    logic [5:0]  m_last;
    logic        exp_busy;

    logic [7:0] rx_bytes [$];
    int         rx_runs [$];
    bit         rx_ok [$];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    matrix_accel_soc #(
        .PRF_LOG_P    (PrfLogP),
        .PRF_LOG_Q    (PrfLogQ),
        .IDCODE       (IdCode),
        .CLKS_PER_BIT (Clks)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx    (tx),
        .rx    (1'b1),
        .tck   (tck),
        .tms   (tms),
        .trstn (trstn),
        .tdi   (tdi),
        .tdo   (tdo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One tck period: low phase (tdo sampled at its end), then high phase.
    task automatic jtag_bit(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        repeat (Half) @(negedge clk);
        o   = tdo;
        tck = 1'b1;
        repeat (Half) @(negedge clk);
        tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic o;
        for (int i = 0; i < 5; i++) jtag_bit(1'b1, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
    endtask

    task automatic shift_ir(input logic [4:0] val, output logic [4:0] out);
        logic o;
        out = '0;
        jtag_bit(1'b1, 1'b0, o);
        jtag_bit(1'b1, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            jtag_bit(i == 4, val[i], o);
            out[i] = o;
        end
        jtag_bit(1'b1, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
    endtask

    task automatic shift_dr(input logic [39:0] val, input int len, output logic [39:0] out);
        logic o;
        out = '0;
        jtag_bit(1'b1, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
        for (int i = 0; i < len; i++) begin
            jtag_bit(i == len - 1, val[i], o);
            out[i] = o;
        end
        jtag_bit(1'b1, 1'b0, o);
        jtag_bit(1'b0, 1'b0, o);
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] addr);
        case (addr)
            6'd0:    return m_reg0;
            6'd1:    return {31'b0, exp_busy};
            6'd2:    return (PrfLogQ << 8) | PrfLogP;
            6'd3:    return m_reg3;
            default: return 32'h0;
        endcase
    endfunction

    // Every REGACC scan checks what its Capture-DR returned, then updates the model.
    task automatic regacc(input string tag, input logic [1:0] op, input logic [5:0] addr,
                          input logic [31:0] data);
        logic [39:0] out;
        logic [39:0] exp;
        exp = {m_last, m_rdata, 2'b00};
        shift_dr({addr, data, op}, 40, out);
        check_eq(tag, out, exp);
        if (op == 2'd2) begin
            if (addr == 6'd0) m_reg0 = data;
            if (addr == 6'd3) m_reg3 = data;
        end else if (op == 2'd1) begin
            m_rdata = model_read(addr);
            m_last  = addr;
        end
    endtask

    task automatic rx_frame();
        logic [7:0] b = '0;
        int run = 0;
        bit run_done = 1'b0;
        bit ok = 1'b1;
        bit aborted = 1'b0;
        int k;
        for (int c = 0; c < 10 * Clks; c++) begin
            if (!rst_n) begin
                aborted = 1'b1;
                break;
            end
            if (!run_done) begin
                if (tx == 1'b0) run++;
                else run_done = 1'b1;
            end
            if (c % Clks == Clks / 2) begin
                k = c / Clks;
                if (k == 0)      ok = ok && (tx == 1'b0);
                else if (k == 9) ok = ok && (tx == 1'b1);
                else             b[k-1] = tx;
            end
            @(negedge clk);
        end
        if (!aborted) begin
            rx_bytes.push_back(b);
            rx_runs.push_back(run);
            rx_ok.push_back(ok);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) rx_frame();
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] dout;
        logic [4:0]  iout;
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        o;

        m_reg0 = '0; m_reg3 = '0; m_rdata = '0; m_last = '0; exp_busy = 1'b0;
        rst_n = 1'b0; tck = 1'b0; tms = 1'b0; trstn = 1'b1; tdi = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_tdo", tdo, 0);
        check_eq("rst_reg0", dut.i_ctrl_regs.reg_q_o[0], 0);
        check_eq("rst_reg1", dut.i_ctrl_regs.reg_q_o[1], 0);
        check_eq("rst_reg3", dut.i_ctrl_regs.reg_q_o[3], 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        tap_reset();
        shift_dr(40'h0, 32, dout);
        check_eq("idcode", dout, {32'h0, IdCode});
        check_eq("tdo_idle", tdo, 0);
        shift_ir(5'h11, iout);
        check_eq("ir_capture", iout, 5'b00001);

        regacc("acc_first", 2'd0, 6'd0, 32'h0);
        regacc("acc_wr3", 2'd2, 6'd3, 32'hDEADBEEF);
        regacc("acc_rd3", 2'd1, 6'd3, 32'h0);
        regacc("acc_rd3_res", 2'd0, 6'd0, 32'h0);
        regacc("acc_rd_cfg", 2'd1, 6'd2, 32'h0);
        regacc("acc_wr_cfg", 2'd2, 6'd2, 32'h12345678);
        regacc("acc_rd_cfg2", 2'd1, 6'd2, 32'h0);
        regacc("acc_cfg_res", 2'd3, 6'd0, 32'h0);

        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 3))
                0:       addr = 6'd0;
                1:       addr = 6'd2;
                2:       addr = 6'd3;
                default: addr = 6'($urandom_range(4, 63));
            endcase
            op   = 2'($urandom_range(0, 3));
            data = $urandom;
            if (addr == 6'd0 && data == 32'hFF) data = 32'h1FF;
            regacc("acc_rand", op, addr, data);
        end
        regacc("acc_rand_last", 2'd0, 6'd0, 32'h0);

        // UART: frame, busy readback, write-while-busy dropped.
        mon_en = 1'b1;
        regacc("uart_wr", 2'd2, 6'd1, 32'h41);
        exp_busy = 1'b1;
        regacc("uart_rd_busy", 2'd1, 6'd1, 32'h0);
        regacc("uart_wr_busy", 2'd2, 6'd1, 32'h55);
        repeat (1000) @(negedge clk);
        exp_busy = 1'b0;
        regacc("uart_rd_idle", 2'd1, 6'd1, 32'h0);
        regacc("uart_idle_res", 2'd0, 6'd0, 32'h0);
        check_eq("uart_nframes", rx_bytes.size(), 1);
        if (rx_bytes.size() > 0) begin
            check_eq("uart_byte", rx_bytes[0], 8'h41);
            check_eq("uart_start_len", rx_runs[0], Clks);
            check_eq("uart_framing", rx_ok[0], 1);
        end

        // BYPASS: one-bit delay with a leading captured 0.
        shift_ir(5'h1F, iout);
        check_eq("ir_capture2", iout, 5'b00001);
        shift_dr(40'h0A5, 9, dout);
        check_eq("bypass", dout, 40'h14A);

        // TAP reset keeps register contents.
        trstn = 1'b0;
        repeat (20) @(negedge clk);
        trstn = 1'b1;
        repeat (10) @(negedge clk);
        jtag_bit(1'b0, 1'b0, o);
        shift_dr(40'h0, 32, dout);
        check_eq("trst_idcode", dout, {32'h0, IdCode});
        shift_ir(5'h11, iout);
        regacc("trst_rd3", 2'd1, 6'd3, 32'h0);
        regacc("trst_rd3_res", 2'd0, 6'd0, 32'h0);

        regacc("finish_wr", 2'd2, 6'd0, 32'hFF);
        check_eq("finish_marker", dut.i_ctrl_regs.reg_q_o[0], 32'hFF);

        // System reset in the middle of a frame.
        regacc("uart_wr2", 2'd2, 6'd1, 32'hC3);
        repeat (40) @(negedge clk);
        check_eq("uart_mid_start", tx, 0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_tx", tx, 1);
        check_eq("rst_mid_reg0", dut.i_ctrl_regs.reg_q_o[0], 0);
        check_eq("rst_mid_reg3", dut.i_ctrl_regs.reg_q_o[3], 0);
        check_eq("rst_mid_tdo", tdo, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
